pkt_fifo: RTL
=============

PKT_FIFO -- requirements
Module: pkt_fifo

Interface
REQ-001 Parameters SHALL be (name, default, meaning): DWIDTH, 8, data word width; AWIDTH, 4, address width, depth = 2**AWIDTH words; ALMOST_FULL_VALUE, 12, almost-full threshold on usedw_o; ALMOST_EMPTY_VALUE, 2, almost-empty threshold on committed words; DROP_CNT_WIDTH, 16, drop counter width.
REQ-002 One clock; reset is synchronous and active-high.
REQ-003 Ports SHALL be (name, direction, width, meaning):
- clk_i  in  1  clock
- srst_i  in  1  synchronous active-high reset
- data_i  in  DWIDTH  write word
- sop_i  in  1  first word of packet
- eop_i  in  1  last word of packet
- wrreq_i  in  1  write request
- rdreq_i  in  1  read request (pop)
- q_o  out  DWIDTH  head word, showahead
- q_sop_o  out  1  head word is start of packet
- q_eop_o  out  1  head word is end of packet
- empty_o  out  1  no committed word available
- full_o  out  1  storage full (committed + in-progress)
- usedw_o  out  AWIDTH+1  words stored, including in-progress packet
- almost_full_o  out  1  usedw_o >= ALMOST_FULL_VALUE
- almost_empty_o  out  1  committed words < ALMOST_EMPTY_VALUE
- drop_o  out  1  one-cycle pulse: packet discarded
- drop_cnt_o  out  DROP_CNT_WIDTH  saturating count of discarded packets

Function
REQ-004 Storage SHALL hold 2**AWIDTH entries of {sop, eop, data}; pointers rd_ptr, commit_ptr, wr_ptr SHALL be AWIDTH+1 bits and wrap modulo 2**(AWIDTH+1).
REQ-005 Write FSM SHALL have states IDLE, PKT (packet in progress), DISCARD (drop rest of packet until eop).
REQ-006 IDLE: wrreq_i with sop_i and not full writes the word; with eop_i also set, the packet commits immediately and FSM stays IDLE, else -> PKT; wrreq_i without sop_i SHALL be ignored, with no drop_o.
REQ-007 PKT: an accepted word without sop_i is written; eop_i commits (commit_ptr <= wr_ptr+1) and the FSM goes -> IDLE.
REQ-008 PKT, wrreq_i with sop_i: the partial packet SHALL be discarded (wr_ptr rolled back to commit_ptr); the new word is written at the old commit_ptr; drop_o pulses and the FSM stays in PKT, or goes -> IDLE if eop_i.
REQ-009 Write while full_o (any state except DISCARD): wr_ptr SHALL roll back to commit_ptr and drop_o pulses; the FSM goes -> DISCARD, or -> IDLE if eop_i.
REQ-010 DISCARD: all words SHALL be ignored; eop_i -> IDLE; sop_i without eop_i starts a new packet as in IDLE, with no additional drop.
REQ-011 Commit latency: the word with eop_i written at edge N SHALL be readable (empty_o=0, valid q_o) in the cycle after edge N.
REQ-012 Read: rdreq_i with empty_o=0 SHALL pop the head at the next edge; rdreq_i while empty_o=1 SHALL be ignored; q_o/q_sop_o/q_eop_o SHALL be 0 while empty_o=1.
REQ-013 Simultaneous accepted read and write SHALL both occur; usedw_o SHALL be unchanged.
REQ-014 A rollback SHALL free its space by the cycle after the dropping edge; a concurrent read in that cycle SHALL still be applied.
REQ-015 usedw_o = wr_ptr - rd_ptr; full_o = (usedw_o == 2**AWIDTH); empty_o = (rd_ptr == commit_ptr).
REQ-016 All status outputs SHALL be derived from registers only, with no combinational path from any input.
REQ-017 drop_cnt_o SHALL increment by 1 per drop_o pulse and saturate at all-ones.
REQ-018 A packet longer than 2**AWIDTH words SHALL always be dropped, per REQ-009.

Reset
REQ-019 srst_i SHALL zero all pointers, set the FSM to IDLE, and clear drop_cnt_o; reset values: empty_o=1, full_o=0, usedw_o=0, almost_full_o=0, almost_empty_o=1, drop_o=0, q_o=q_sop_o=q_eop_o=0.
REQ-020 srst_i SHALL take priority over wrreq_i/rdreq_i in the same cycle; storage contents need not be cleared.

Verification (DWIDTH=8, AWIDTH=4, AF=12, AE=2)
REQ-021 Write a 4-word packet 0x11..0x14 -> empty_o=1 until after the eop edge, then usedw_o=4, q_o=0x11 with q_sop_o=1; 4 pops return 0x11..0x14 with q_eop_o=1 on 0x14, then empty_o=1.
REQ-022 Write a 20-word packet into an empty FIFO -> full_o=1 after word 16; word 17 gives drop_o pulse, usedw_o=0 next cycle, words 18-20 ignored, drop_cnt_o=1, empty_o stays 1.
REQ-023 Write sop 0xA0, 0xA1, then sop 0xB0, eop 0xB1 -> one drop_o; only 0xB0, 0xB1 are readable; drop_cnt_o=1.
REQ-024 Commit 3 packets of 4 words, then 4 cycles of simultaneous read and write of a new packet -> usedw_o held at 12, almost_full_o=1 throughout, read order preserved.
REQ-025 Assert srst_i after 2 words of a partial packet, then write words without sop_i -> all reset values restored; the words are ignored; empty_o=1, drop_cnt_o=0.
REQ-026 Drain to 1 committed word -> almost_empty_o=1; drive 0xFFFF+2 drops -> drop_cnt_o stays 0xFFFF.

Source files
------------

// File: rtl/pkt_fifo.sv
// Packet FIFO with showahead read. A packet becomes readable only once its eop word is written.
// Partial packets are rolled back and counted as drops on overflow or when a new sop interrupts them.
module pkt_fifo #(
    parameter int unsigned DWIDTH             = 8,
    parameter int unsigned AWIDTH             = 4,
    parameter int unsigned ALMOST_FULL_VALUE  = 12,
    parameter int unsigned ALMOST_EMPTY_VALUE = 2,
    parameter int unsigned DROP_CNT_WIDTH     = 16
) (
    input  logic                      clk_i,
    input  logic                      srst_i,
    input  logic [DWIDTH-1:0]         data_i,
    input  logic                      sop_i,
    input  logic                      eop_i,
    input  logic                      wrreq_i,
    input  logic                      rdreq_i,
    output logic [DWIDTH-1:0]         q_o,
    output logic                      q_sop_o,
    output logic                      q_eop_o,
    output logic                      empty_o,
    output logic                      full_o,
    output logic [AWIDTH:0]           usedw_o,
    output logic                      almost_full_o,
    output logic                      almost_empty_o,
    output logic                      drop_o,
    output logic [DROP_CNT_WIDTH-1:0] drop_cnt_o
);

    localparam int unsigned PW    = AWIDTH + 1;
    localparam int unsigned EW    = DWIDTH + 2;
    localparam int unsigned DEPTH = 1 << AWIDTH;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PKT,
        ST_DISCARD
    } state_e;

    state_e                    state_q, state_d;
    logic [PW-1:0]             wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]             commit_ptr_q, commit_ptr_d;
    logic [PW-1:0]             rd_ptr_q, rd_ptr_d;
    logic                      drop_q, drop_d;
    logic [DROP_CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;
    logic [EW-1:0]             mem_q [DEPTH];

    logic                      we;
    logic [AWIDTH-1:0]         waddr;
    logic [PW-1:0]             used;
    logic [PW-1:0]             committed;
    logic                      full_w;
    logic                      empty_w;
    logic [EW-1:0]             head;

    // Status is a pure function of the pointer registers.
    assign used      = wr_ptr_q - rd_ptr_q;
    assign committed = commit_ptr_q - rd_ptr_q;
    assign full_w    = (used == PW'(DEPTH));
    assign empty_w   = (rd_ptr_q == commit_ptr_q);
    assign head      = mem_q[rd_ptr_q[AWIDTH-1:0]];

    assign usedw_o        = used;
    assign full_o         = full_w;
    assign empty_o        = empty_w;
    assign almost_full_o  = (used >= PW'(ALMOST_FULL_VALUE));
    assign almost_empty_o = (committed < PW'(ALMOST_EMPTY_VALUE));
    assign drop_o         = drop_q;
    assign drop_cnt_o     = drop_cnt_q;
    assign q_o            = empty_w ? '0 : head[DWIDTH-1:0];
    assign q_sop_o        = empty_w ? 1'b0 : head[EW-1];
    assign q_eop_o        = empty_w ? 1'b0 : head[EW-2];

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_q      <= ST_IDLE;
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            rd_ptr_q     <= '0;
            drop_q       <= 1'b0;
            drop_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            drop_q       <= drop_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    // Storage is not reset; only pointers define validity.
    always_ff @(posedge clk_i) begin
        if (we && !srst_i) begin
            mem_q[waddr] <= {sop_i, eop_i, data_i};
        end
    end

    // Write-side FSM: accept, commit, roll back or discard.
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        drop_d       = 1'b0;
        we           = 1'b0;
        waddr        = wr_ptr_q[AWIDTH-1:0];

        if (wrreq_i) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (sop_i) begin
                        if (full_w) begin
                            drop_d  = 1'b1;
                            state_d = eop_i ? ST_IDLE : ST_DISCARD;
                        end else begin
                            we       = 1'b1;
                            wr_ptr_d = wr_ptr_q + PW'(1);
                            if (eop_i) commit_ptr_d = wr_ptr_q + PW'(1);
                            else       state_d      = ST_PKT;
                        end
                    end
                end
                ST_PKT: begin
                    if (full_w) begin
                        drop_d   = 1'b1;
                        wr_ptr_d = commit_ptr_q;
                        state_d  = eop_i ? ST_IDLE : ST_DISCARD;
                    end else if (sop_i) begin
                        // Restart: new packet overwrites the abandoned partial one.
                        drop_d   = 1'b1;
                        we       = 1'b1;
                        waddr    = commit_ptr_q[AWIDTH-1:0];
                        wr_ptr_d = commit_ptr_q + PW'(1);
                        if (eop_i) begin
                            commit_ptr_d = commit_ptr_q + PW'(1);
                            state_d      = ST_IDLE;
                        end
                    end else begin
                        we       = 1'b1;
                        wr_ptr_d = wr_ptr_q + PW'(1);
                        if (eop_i) begin
                            commit_ptr_d = wr_ptr_q + PW'(1);
                            state_d      = ST_IDLE;
                        end
                    end
                end
                ST_DISCARD: begin
                    if (eop_i) begin
                        state_d = ST_IDLE;
                    end else if (sop_i && !full_w) begin
                        we       = 1'b1;
                        wr_ptr_d = wr_ptr_q + PW'(1);
                        state_d  = ST_PKT;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        if (rdreq_i && !empty_w) rd_ptr_d = rd_ptr_q + PW'(1);
    end

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop_d && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + DROP_CNT_WIDTH'(1);
    end

endmodule
